// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared types and sizing helpers for the FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int c_stats_w = 16;

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first request after i_last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_pick,
  output logic               o_any
);

  always_comb begin
    int w_j;
    o_pick = '0;
    o_any  = 1'b0;
    w_j    = 0;
    // Scan last+1 .. last+NUM_REQ, wrapping; the previous owner comes last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_j = int'(i_last) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_any  = 1'b1;
        o_pick = IDX_W'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port.
//            Optional per-requester beat counters: FIFO_WR_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_fifo_write,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*c_stats_w-1:0]  o_beat_cnt,
  input  logic                          i_stats_clr
`endif
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_cnt_w = cnt_width(MAX_BURST);

  arb_state_e         r_state, w_state_nxt;
  logic [c_idx_w-1:0] r_owner, w_owner_nxt;
  logic [c_idx_w-1:0] r_last,  w_last_nxt;
  logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;

  logic [c_idx_w-1:0] w_pick;
  logic               w_any;
  logic               w_own;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_owner_valid;
  logic               w_xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_pick (
    .i_req  (i_req_valid),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_own         = (r_state == OWN);
  assign w_owner_oh    = w_own ? (NUM_REQ'(1) << r_owner) : '0;
  assign w_owner_valid = |(i_req_valid & w_owner_oh);
  assign w_xfer        = w_owner_valid & ~i_fifo_full;
  assign w_cnt_inc     = r_cnt + 1'b1;

  assign o_grant      = w_owner_oh;
  assign o_busy       = w_own;
  assign o_req_ready  = i_fifo_full ? '0 : w_owner_oh;
  assign o_fifo_write = w_xfer;
  // Non-owner slices never reach the output, even when X.
  assign o_fifo_data  = w_xfer ? i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH]
                               : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
      r_last  <= c_idx_w'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OWN;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (!w_owner_valid) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          if (w_cnt_inc == c_cnt_w'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
      logic [c_stats_w-1:0] r_beats;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_beats <= '0;
        end else if (i_stats_clr) begin
          r_beats <= '0;
        end else if (w_xfer && (r_owner == c_idx_w'(k)) && (r_beats != '1)) begin
          r_beats <= r_beats + 1'b1;
        end
      end

      assign o_beat_cnt[k*c_stats_w +: c_stats_w] = r_beats;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed vector table plus reset / round-robin sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data;
  logic            fifo_full;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NR*16-1:0] beat_cnt;
  logic             stats_clr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_fifo_write (fifo_write),
    .o_fifo_data  (fifo_data),
    .i_fifo_full  (fifo_full)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .o_beat_cnt   (beat_cnt),
    .i_stats_clr  (stats_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Slice k carries (k+1) in the top nibble and the row base in the low byte.
  task automatic drive(input logic [3:0] v, input logic [7:0] base, input logic full);
    req_valid = v;
    fifo_full = full;
    for (int k = 0; k < NR; k++)
      req_data[k*DW +: DW] = (32'h1000_0000 * (k + 1)) | {24'h0, base};
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  base;
    logic        full;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic        write;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    vecs[0]  = '{4'b0001, 8'hA0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{4'b0001, 8'hA0, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A0, 1'b1};
    vecs[2]  = '{4'b0001, 8'hA1, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A1, 1'b1};
    vecs[3]  = '{4'b0001, 8'hA2, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A2, 1'b1};
    vecs[4]  = '{4'b0001, 8'hA3, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A3, 1'b1};
    vecs[5]  = '{4'b0001, 8'hA4, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[6]  = '{4'b0001, 8'hA4, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A4, 1'b1};
    vecs[7]  = '{4'b0001, 8'hA5, 1'b0, 4'b0001, 4'b0001, 1'b1, 32'h1000_00A5, 1'b1};
    vecs[8]  = '{4'b0000, 8'hA6, 1'b0, 4'b0001, 4'b0001, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{4'b0000, 8'hA6, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{4'b1010, 8'hB0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{4'b1010, 8'hB0, 1'b0, 4'b0010, 4'b0010, 1'b1, 32'h2000_00B0, 1'b1};
    vecs[12] = '{4'b1010, 8'hB1, 1'b0, 4'b0010, 4'b0010, 1'b1, 32'h2000_00B1, 1'b1};
    vecs[13] = '{4'b1000, 8'hB2, 1'b0, 4'b0010, 4'b0010, 1'b0, 32'h0,         1'b1};
    vecs[14] = '{4'b1000, 8'hB2, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[15] = '{4'b1000, 8'hB3, 1'b0, 4'b1000, 4'b1000, 1'b1, 32'h4000_00B3, 1'b1};
    vecs[16] = '{4'b0000, 8'hB4, 1'b0, 4'b1000, 4'b1000, 1'b0, 32'h0,         1'b1};
    vecs[17] = '{4'b0000, 8'hB4, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[18] = '{4'b0100, 8'hC0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[19] = '{4'b0100, 8'hC0, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h3000_00C0, 1'b1};
    vecs[20] = '{4'b0100, 8'hC1, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h3000_00C1, 1'b1};
    vecs[21] = '{4'b0100, 8'hC2, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b1};
    vecs[22] = '{4'b0100, 8'hC2, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b1};
    vecs[23] = '{4'b0100, 8'hC2, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b1};
    vecs[24] = '{4'b0100, 8'hC2, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h3000_00C2, 1'b1};
    vecs[25] = '{4'b0100, 8'hC3, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h3000_00C3, 1'b1};
    vecs[26] = '{4'b0100, 8'hC4, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
    vecs[27] = '{4'b0000, 8'hC4, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b1};
    vecs[28] = '{4'b0000, 8'hC4, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0};
  end

  initial begin
    int sent [NR];
    int writes;
    int grants;
    int beats_in;
    int exp_own;
    logic [3:0] prev_grant;
    bit done;

    rst = 1'b1;
    drive(4'b1111, 8'h00, 1'b0);
`ifdef FIFO_WR_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_busy",  64'(busy), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_write", 64'(fifo_write), 64'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].valid, vecs[i].base, vecs[i].full);
      #1;
      chk($sformatf("vec%0d_grant", i), 64'(grant),      64'(vecs[i].grant));
      chk($sformatf("vec%0d_ready", i), 64'(req_ready),  64'(vecs[i].ready));
      chk($sformatf("vec%0d_write", i), 64'(fifo_write), 64'(vecs[i].write));
      chk($sformatf("vec%0d_data",  i), 64'(fifo_data),  64'(vecs[i].data));
      chk($sformatf("vec%0d_busy",  i), 64'(busy),       64'(vecs[i].busy));
    end

    // Reset in the middle of a burst owned by requester 2.
    @(negedge clk);
    drive(4'b0100, 8'hE0, 1'b0);
    @(negedge clk);
    drive(4'b0100, 8'hE0, 1'b0);
    #1;
    chk("mid_beat1_write", 64'(fifo_write), 64'h1);
    chk("mid_beat1_grant", 64'(grant), 64'h4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst = 1'b1;
      drive(4'b0100, 8'hE1, 1'b0);
      #1;
      chk($sformatf("mid_rst%0d_write", c), 64'(fifo_write), 64'h0);
      chk($sformatf("mid_rst%0d_grant", c), 64'(grant), 64'h0);
      chk($sformatf("mid_rst%0d_ready", c), 64'(req_ready), 64'h0);
    end

    // All four requesters valid with 8 beats each after reset release.
    for (int k = 0; k < NR; k++) sent[k] = 0;
    writes = 0; grants = 0; beats_in = 0; prev_grant = '0; done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      fifo_full = 1'b0;
      for (int k = 0; k < NR; k++) begin
        req_valid[k] = (sent[k] < 8);
        req_data[k*DW +: DW] = 32'hD000_0000 | 32'(k << 8) | 32'(sent[k]);
      end
      #1;
      if (grant != 0 && prev_grant == 0) begin
        chk($sformatf("rr_grant%0d", grants), 64'(grant),
            64'(4'b0001 << order[grants % 8]));
        grants++;
        beats_in = 0;
      end
      if (grant == 0 && prev_grant != 0)
        chk($sformatf("rr_beats_grant%0d", grants - 1), 64'(beats_in), 64'd4);
      if (fifo_write) begin
        exp_own = (grants == 0) ? 0 : order[(grants - 1) % 8];
        chk($sformatf("rr_data%0d", writes), 64'(fifo_data),
            64'(32'hD000_0000 | 32'(exp_own << 8) | 32'(sent[exp_own])));
        sent[exp_own]++;
        writes++;
        beats_in++;
      end
      prev_grant = grant;
      if (writes == 32 && grant == 0) done = 1;
    end
    chk("rr_done", 64'(done), 64'h1);
    chk("rr_total_writes", 64'(writes), 64'd32);
    chk("rr_total_grants", 64'(grants), 64'd8);

`ifdef FIFO_WR_ARBITER_STATS_EN
    @(negedge clk);
    req_valid = '0;
    #1;
    for (int k = 0; k < NR; k++)
      chk($sformatf("stats_cnt%0d", k), 64'(beat_cnt[k*16 +: 16]), 64'd8);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    for (int k = 0; k < NR; k++)
      chk($sformatf("stats_clr%0d", k), 64'(beat_cnt[k*16 +: 16]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
